// File: rtl/mips_pkg.sv
// mips_pkg: opcode, funct, ALU-code, alu_op and FSM state constants shared by the
// multicycle MIPS control unit and its ALU decoder.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_EXECUTE = 4'd6;
    localparam logic [3:0] S_ALUWB   = 4'd7;
    localparam logic [3:0] S_BRANCH  = 4'd8;
    localparam logic [3:0] S_ADDIEX  = 4'd9;
    localparam logic [3:0] S_ADDIWB  = 4'd10;
    localparam logic [3:0] S_JUMP    = 4'd11;

endpackage

// File: rtl/mips_multicycle_control_alu_decoder.sv
// alu_decoder: maps alu_op and the R-type funct field onto the 4-bit ALU control code,
// flagging funct values the datapath does not implement.
module alu_decoder
    import mips_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [5:0] funct,
    output logic [3:0] alu_control,
    output logic       funct_valid
);

    logic [3:0] funct_code;

    always_comb begin
        funct_valid = 1'b1;
        funct_code  = ALU_ADD;
        case (funct)
            FN_ADD:  funct_code = ALU_ADD;
            FN_SUB:  funct_code = ALU_SUB;
            FN_AND:  funct_code = ALU_AND;
            FN_OR:   funct_code = ALU_OR;
            FN_NOR:  funct_code = ALU_NOR;
            FN_SLT:  funct_code = ALU_SLT;
            default: funct_valid = 1'b0;
        endcase
    end

    assign alu_control = (alu_op == ALUOP_SUB)   ? ALU_SUB :
                         (alu_op == ALUOP_FUNCT) ? funct_code : ALU_ADD;

endmodule

// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: one-state-per-clock control FSM for the multicycle MIPS
// datapath; Moore outputs from the state register, alu_control and pc_en are Mealy.
module mips_multicycle_control
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic [3:0] alu_control,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic       i_or_d,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       illegal_op,
    output logic [3:0] state_dbg
);

    logic [3:0] state_q, state_d;
    alu_op_t    alu_op;
    logic       funct_valid, op_legal;
    logic       pc_write, branch, ir_write_m, mem_write_m, reg_write_m;

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct       (funct),
        .alu_control (alu_control),
        .funct_valid (funct_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    assign op_legal = (opcode == OP_LW) || (opcode == OP_SW) || (opcode == OP_BEQ) ||
                      (opcode == OP_ADDI) || (opcode == OP_J) ||
                      ((opcode == OP_RTYPE) && funct_valid);

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:   state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = funct_valid ? S_EXECUTE : S_FETCH;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:  state_d = (opcode == OP_LW) ? S_MEMRD :
                                 (opcode == OP_SW) ? S_MEMWR : S_FETCH;
            S_MEMRD:   state_d = S_MEMWB;
            S_EXECUTE: state_d = S_ALUWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            default:   state_d = S_FETCH;
        endcase
    end

    always_comb begin
        alu_op      = ALUOP_ADD;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        pc_src      = 2'b00;
        pc_write    = 1'b0;
        branch      = 1'b0;
        i_or_d      = 1'b0;
        ir_write_m  = 1'b0;
        mem_write_m = 1'b0;
        reg_write_m = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        case (state_q)
            S_FETCH: begin
                alu_src_b  = 2'b01;
                ir_write_m = 1'b1;
                pc_write   = 1'b1;
            end
            S_DECODE:  alu_src_b = 2'b11;
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD:   i_or_d = 1'b1;
            S_MEMWB: begin
                mem_to_reg  = 1'b1;
                reg_write_m = 1'b1;
            end
            S_MEMWR: begin
                i_or_d      = 1'b1;
                mem_write_m = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                reg_dst     = 1'b1;
                reg_write_m = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_SUB;
                pc_src    = 2'b01;
                branch    = 1'b1;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_ADDIWB:  reg_write_m = 1'b1;
            S_JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset gates the architectural write strobes immediately, even mid-instruction.
    assign pc_en      = ~reset & (pc_write | (branch & zero));
    assign ir_write   = ~reset & ir_write_m;
    assign mem_write  = ~reset & mem_write_m;
    assign reg_write  = ~reset & reg_write_m;
    assign illegal_op = (state_q == S_DECODE) && !op_legal;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb_mips_multicycle_control: directed and randomized instruction streams checked
// cycle by cycle against an instruction-level reference model.
module tb_mips_multicycle_control;
    import mips_pkg::*;

    typedef struct packed {
        logic [3:0] alu;
        logic       src_a;
        logic [1:0] src_b;
        logic [1:0] pc_src;
        logic       pc_en;
        logic       i_or_d;
        logic       ir_write;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       illegal;
        logic [3:0] st;
    } outs_t;

    logic       clk = 1'b0;
    logic       reset, zero;
    logic [5:0] opcode, funct;
    logic [3:0] alu_control, state_dbg;
    logic       alu_src_a, pc_en, i_or_d, ir_write, mem_write, reg_write;
    logic       reg_dst, mem_to_reg, illegal_op;
    logic [1:0] alu_src_b, pc_src;
    outs_t      got;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    mips_multicycle_control dut (
        .clk         (clk),
        .reset       (reset),
        .opcode      (opcode),
        .funct       (funct),
        .zero        (zero),
        .alu_control (alu_control),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .pc_src      (pc_src),
        .pc_en       (pc_en),
        .i_or_d      (i_or_d),
        .ir_write    (ir_write),
        .mem_write   (mem_write),
        .reg_write   (reg_write),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .illegal_op  (illegal_op),
        .state_dbg   (state_dbg)
    );

    assign got = {alu_control, alu_src_a, alu_src_b, pc_src, pc_en, i_or_d, ir_write,
                  mem_write, reg_write, reg_dst, mem_to_reg, illegal_op, state_dbg};

    function automatic logic r_ok(logic [5:0] fn);
        return fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
    endfunction

    function automatic logic [3:0] r_code(logic [5:0] fn);
        case (fn)
            6'h22:   return 4'b0110;
            6'h24:   return 4'b0000;
            6'h25:   return 4'b0001;
            6'h27:   return 4'b1100;
            6'h2A:   return 4'b0111;
            default: return 4'b0010;
        endcase
    endfunction

    // Cycles from FETCH to the next FETCH for one instruction.
    function automatic int ilen(logic [5:0] op, logic [5:0] fn);
        case (op)
            6'h23:   return 5;
            6'h2B:   return 4;
            6'h00:   return r_ok(fn) ? 4 : 2;
            6'h08:   return 4;
            6'h04:   return 3;
            6'h02:   return 3;
            default: return 2;
        endcase
    endfunction

    // Expected outputs in cycle k of an instruction (k=0 is FETCH).
    function automatic outs_t model(logic [5:0] op, logic [5:0] fn, int k, logic z, logic rst);
        outs_t o;
        o = '0;
        o.alu = 4'b0010;
        if (k == 0) begin
            o.src_b = 2'b01; o.ir_write = 1'b1; o.pc_en = 1'b1; o.st = S_FETCH;
        end else if (k == 1) begin
            o.src_b = 2'b11; o.st = S_DECODE; o.illegal = (ilen(op, fn) == 2);
        end else if (op == 6'h23 || op == 6'h2B) begin
            if (k == 2) begin
                o.src_a = 1'b1; o.src_b = 2'b10; o.st = S_MEMADR;
            end else if (op == 6'h2B) begin
                o.i_or_d = 1'b1; o.mem_write = 1'b1; o.st = S_MEMWR;
            end else if (k == 3) begin
                o.i_or_d = 1'b1; o.st = S_MEMRD;
            end else begin
                o.mem_to_reg = 1'b1; o.reg_write = 1'b1; o.st = S_MEMWB;
            end
        end else if (op == 6'h00) begin
            if (k == 2) begin
                o.src_a = 1'b1; o.alu = r_code(fn); o.st = S_EXECUTE;
            end else begin
                o.reg_dst = 1'b1; o.reg_write = 1'b1; o.st = S_ALUWB;
            end
        end else if (op == 6'h08) begin
            if (k == 2) begin
                o.src_a = 1'b1; o.src_b = 2'b10; o.st = S_ADDIEX;
            end else begin
                o.reg_write = 1'b1; o.st = S_ADDIWB;
            end
        end else if (op == 6'h04) begin
            o.src_a = 1'b1; o.alu = 4'b0110; o.pc_src = 2'b01; o.pc_en = z; o.st = S_BRANCH;
        end else begin
            o.pc_src = 2'b10; o.pc_en = 1'b1; o.st = S_JUMP;
        end
        if (rst) begin
            o.pc_en = 1'b0; o.ir_write = 1'b0; o.mem_write = 1'b0; o.reg_write = 1'b0;
        end
        return o;
    endfunction

    task automatic check(input outs_t e, input string tag);
        checks++;
        assert (got === e) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, e);
        end
    endtask

    // Runs one instruction; reset is raised in cycle rst_at (if reached), aborting it.
    task automatic run(input logic [5:0] op, input logic [5:0] fn, input int rst_at, input int zforce);
        int n;
        n = ilen(op, fn);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            opcode = op;
            funct  = fn;
            zero   = (zforce < 0) ? 1'($urandom_range(0, 1)) : 1'(zforce);
            reset  = (k == rst_at);
            #1 check(model(op, fn, k, zero, reset),
                     $sformatf("op%02h_fn%02h_k%0d_z%0d_r%0d", op, fn, k, zero, reset));
            if (k == rst_at) break;
        end
    endtask

    initial begin
        logic [5:0] ops [6];
        logic [5:0] fns [6];
        ops = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h08, 6'h02};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
        reset  = 1'b1;
        opcode = 6'h00;
        funct  = 6'h00;
        zero   = 1'b0;
        @(negedge clk);
        #1 check(model(6'h00, 6'h00, 0, 1'b0, 1'b1), "reset_cycle1");
        @(negedge clk);
        #1 check(model(6'h00, 6'h00, 0, 1'b0, 1'b1), "reset_cycle2");
        run(6'h23, 6'h00, -1, -1);
        run(6'h00, 6'h22, -1, -1);
        run(6'h00, 6'h2A, -1, -1);
        run(6'h00, 6'h27, -1, -1);
        run(6'h04, 6'h00, -1, 1);
        run(6'h04, 6'h00, -1, 0);
        run(6'h3F, 6'h00, -1, -1);
        run(6'h00, 6'h00, -1, -1);
        run(6'h2B, 6'h00, 3, -1);
        run(6'h02, 6'h00, -1, -1);
        for (int i = 0; i < 120; i++) begin
            logic [5:0] op, fn;
            int         pick, rst_at;
            pick   = $urandom_range(0, 6);
            op     = (pick == 6) ? 6'($urandom) : ops[pick];
            fn     = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 5)];
            rst_at = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 4) : -1;
            run(op, fn, rst_at, -1);
        end
        @(negedge clk);
        reset = 1'b0;
        #1 check(model(6'h00, 6'h00, 0, 1'b0, 1'b0), "final_fetch");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
